// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider.
//   DIV_WIDTH   : default width of a divide ratio
//   div_t       : divide-ratio / counter type at the default width
//   DIV_STOP    : ratio value that parks the divider
//   half_period : floor(N/2), the low-phase length of a period
`timescale 1ns/1ps
package clkdiv_pkg;
   localparam int unsigned DIV_WIDTH = 16;

   typedef logic [DIV_WIDTH-1:0] div_t;

   localparam div_t DIV_STOP = '0;

   function automatic div_t half_period(input div_t n);
      return n >> 1;
   endfunction
endpackage

// File: rtl/div_shadow_reg.sv
// Shadow register for the divide ratio.
// Captures a new ratio on div_load_i and holds it until the divider reaches
// a point where the ratio may change (a wrap, or any edge while stopped).
// A load arriving on the wrap edge itself bypasses the shadow.
//   clk_i, rst_ni   : clock, async active-low reset
//   div_load_i      : load strobe for div_value_i
//   div_value_i     : new ratio
//   wrap_i          : this edge starts a new period
//   stop_i          : active ratio is zero
//   active_n_i      : currently active ratio
//   next_n_o        : ratio to use from this edge on
//   apply_o         : active ratio should take next_n_o on this edge
//   pending_o       : shadow holds a ratio not yet applied
`timescale 1ns/1ps
module div_shadow_reg
   import clkdiv_pkg::*;
#(
   parameter int unsigned WIDTH       = DIV_WIDTH,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             div_load_i,
   input  logic [WIDTH-1:0] div_value_i,
   input  logic             wrap_i,
   input  logic             stop_i,
   input  logic [WIDTH-1:0] active_n_i,
   output logic [WIDTH-1:0] next_n_o,
   output logic             apply_o,
   output logic             pending_o
);

   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             pending_q, pending_d;
   logic             bypass;

   // Only a wrap takes div_value directly; while stopped a fresh load must
   // pass through the shadow and is applied on the following edge.
   assign bypass   = wrap_i & div_load_i;
   assign apply_o  = wrap_i | (stop_i & pending_q);
   assign next_n_o = bypass    ? div_value_i :
                     pending_q ? shadow_q    : active_n_i;

   always_comb begin
      shadow_d  = shadow_q;
      pending_d = pending_q;
      if (div_load_i) begin
         shadow_d = div_value_i;
      end
      if (div_load_i && !wrap_i) begin
         pending_d = 1'b1;
      end else if (apply_o) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow_q  <= WIDTH'(DEFAULT_DIV);
         pending_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
      end
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider: down-counter from N-1 to 0, a one-cycle
// tick at each wrap and a square output high for ceil(N/2) cycles of each
// period. Ratio changes take effect only at period boundaries.
// Build option: PHASE_RESYNC_EN adds the resync input (forced wrap).
//   clock50      : system clock
//   MR_n         : async active-low master reset
//   enable       : count enable
//   div_value    : new ratio, taken when div_load=1
//   div_load     : load strobe
//   resync       : forced phase restart (PHASE_RESYNC_EN only)
//   load_pending : shadow loaded, not yet applied
//   count_out    : current down-counter value
//   tick         : one-cycle pulse per period
//   clock_out    : divided square output
`timescale 1ns/1ps
module prog_clock_divider
   import clkdiv_pkg::*;
#(
   parameter int unsigned WIDTH       = DIV_WIDTH,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic             clock50,
   input  logic             MR_n,
   input  logic             enable,
   input  logic [WIDTH-1:0] div_value,
   input  logic             div_load,
`ifdef PHASE_RESYNC_EN
   input  logic             resync,
`endif
   output logic             load_pending,
   output logic [WIDTH-1:0] count_out,
   output logic             tick,
   output logic             clock_out
);

   localparam logic [WIDTH-1:0] STOP_N = WIDTH'(DIV_STOP);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] active_q, active_d;
   logic             tick_q, tick_d;
   logic             clk_q, clk_d;
   logic [WIDTH-1:0] next_n;
   logic [WIDTH-1:0] half_n;
   logic             apply;
   logic             stop;
   logic             wrap_evt;
   logic             resync_w;

`ifdef PHASE_RESYNC_EN
   assign resync_w = resync;
`else
   assign resync_w = 1'b0;
`endif

   if (WIDTH == DIV_WIDTH) begin : g_pkg_half
      assign half_n = half_period(active_q);
   end else begin : g_gen_half
      assign half_n = active_q >> 1;
   end

   assign stop     = (active_q == STOP_N);
   assign wrap_evt = !stop && (resync_w || (enable && (count_q == '0)));

   div_shadow_reg #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_shadow (
      .clk_i       (clock50),
      .rst_ni      (MR_n),
      .div_load_i  (div_load),
      .div_value_i (div_value),
      .wrap_i      (wrap_evt),
      .stop_i      (stop),
      .active_n_i  (active_q),
      .next_n_o    (next_n),
      .apply_o     (apply),
      .pending_o   (load_pending)
   );

   always_comb begin
      count_d  = count_q;
      tick_d   = 1'b0;
      clk_d    = clk_q;
      active_d = apply ? next_n : active_q;
      if (stop) begin
         count_d = '0;
         clk_d   = 1'b0;
      end else if (wrap_evt) begin
         // A wrap onto a newly applied zero ratio parks the divider at once.
         if (next_n == STOP_N) begin
            count_d = '0;
            clk_d   = 1'b0;
         end else begin
            count_d = next_n - 1'b1;
            tick_d  = 1'b1;
            clk_d   = 1'b1;
         end
      end else if (enable) begin
         count_d = count_q - 1'b1;
         clk_d   = (count_d >= half_n);
      end
   end

   always_ff @(posedge clock50 or negedge MR_n) begin
      if (!MR_n) begin
         count_q  <= '0;
         active_q <= WIDTH'(DEFAULT_DIV);
         tick_q   <= 1'b0;
         clk_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         active_q <= active_d;
         tick_q   <= tick_d;
         clk_q    <= clk_d;
      end
   end

   assign count_out = count_q;
   assign tick      = tick_q;
   assign clock_out = clk_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
`timescale 1ns/1ps
module tb_prog_clock_divider;
   localparam int W   = 16;
   localparam int DEF = 4;

   logic         clock50 = 1'b0;
   logic         MR_n = 1'b0;
   logic         enable = 1'b0;
   logic         div_load = 1'b0;
   logic         resync = 1'b0;
   logic [W-1:0] div_value = '0;
   logic         load_pending;
   logic [W-1:0] count_out;
   logic         tick;
   logic         clock_out;

   int n_err = 0;
   int n_chk = 0;

   // Reference model: ratio, shadow, pending, and the expected outputs.
   int mN, mSh, mCnt;
   bit mPend, mTick, mClk;

   always #5 clock50 = ~clock50;

   prog_clock_divider #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
      .clock50      (clock50),
      .MR_n         (MR_n),
      .enable       (enable),
      .div_value    (div_value),
      .div_load     (div_load),
`ifdef PHASE_RESYNC_EN
      .resync       (resync),
`endif
      .load_pending (load_pending),
      .count_out    (count_out),
      .tick         (tick),
      .clock_out    (clock_out)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      mN = DEF; mSh = DEF; mPend = 0; mCnt = 0; mTick = 0; mClk = 0;
   endfunction

   // One rising edge with the given inputs. clock_out is derived from the
   // position within the period: high for the first ceil(N/2) cycles.
   function automatic void model_step(input bit en, input bit ld, input int val, input bit rs);
      bit wrap;
      int n;
      wrap = (mN != 0) && (rs || (en && mCnt == 0));
      if (mN == 0) begin
         if (mPend) begin mN = mSh; mPend = 0; end
         if (ld) begin mSh = val; mPend = 1; end
         mCnt = 0; mTick = 0; mClk = 0;
      end else if (wrap) begin
         n = ld ? val : (mPend ? mSh : mN);
         mN = n; mPend = 0;
         if (n == 0) begin
            mCnt = 0; mTick = 0; mClk = 0;
         end else begin
            mCnt = n - 1; mTick = 1;
            mClk = ((n - 1 - mCnt) < (n + 1) / 2);
         end
      end else begin
         if (ld) begin mSh = val; mPend = 1; end
         mTick = 0;
         if (en) begin
            mCnt = mCnt - 1;
            mClk = ((mN - 1 - mCnt) < (mN + 1) / 2);
         end
      end
   endfunction

   task automatic compare_model();
      chk("count_out", 32'(count_out), 32'(mCnt));
      chk("tick", 32'(tick), 32'(mTick));
      chk("clock_out", 32'(clock_out), 32'(mClk));
      chk("load_pending", 32'(load_pending), 32'(mPend));
   endtask

   task automatic cycle();
      @(posedge clock50);
      model_step(enable, div_load, int'(div_value), resync);
      #1;
      compare_model();
   endtask

   task automatic load_cycle(input int v);
      div_load = 1'b1; div_value = W'(v);
      cycle();
      div_load = 1'b0;
   endtask

   // Advance until the model shows the requested count, bounded.
   task automatic run_to_count(input int c);
      int k;
      k = 0;
      while (mCnt != c && k < 200) begin cycle(); k++; end
      if (mCnt != c) chk("run_to_count_bound", 32'(k), 32'd200 + 32'd1);
   endtask

   task automatic pulse_reset();
      #2;
      MR_n = 1'b0;
      #1;
      model_reset();
      compare_model();
      #1;
      MR_n = 1'b1;
   endtask

   initial begin
      int exp_cnt[8];
      int exp_clk[8];
      int exp_tck[8];
      exp_cnt = '{3, 2, 1, 0, 3, 2, 1, 0};
      exp_clk = '{1, 1, 0, 0, 1, 1, 0, 0};
      exp_tck = '{1, 0, 0, 0, 1, 0, 0, 0};

      model_reset();
      #3;
      compare_model();
      chk("reset_count", 32'(count_out), 32'd0);
      chk("reset_pending", 32'(load_pending), 32'd0);
      @(negedge clock50);
      MR_n = 1'b1;

      // DEFAULT_DIV=4 free-running: pinned literal sequence.
      enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("def4_count", 32'(count_out), 32'(exp_cnt[i]));
         chk("def4_clk", 32'(clock_out), 32'(exp_clk[i]));
         chk("def4_tick", 32'(tick), 32'(exp_tck[i]));
      end

      // Load N=3 at count_out=2: pending until the wrap two edges later.
      run_to_count(2);
      load_cycle(3);
      chk("ld3_pending", 32'(load_pending), 32'd1);
      cycle();
      chk("ld3_pending_hold", 32'(load_pending), 32'd1);
      cycle();
      chk("ld3_wrap_count", 32'(count_out), 32'd2);
      chk("ld3_wrap_pending", 32'(load_pending), 32'd0);
      repeat (7) cycle();

      // Load N=5 exactly on the wrap edge: bypass, never pending.
      run_to_count(0);
      load_cycle(5);
      chk("ld5_bypass_count", 32'(count_out), 32'd4);
      chk("ld5_bypass_pending", 32'(load_pending), 32'd0);
      repeat (11) cycle();

      // Stop with N=0, then restart with N=1.
      run_to_count(1);
      load_cycle(0);
      repeat (6) cycle();
      chk("stop_count", 32'(count_out), 32'd0);
      chk("stop_clk", 32'(clock_out), 32'd0);
      load_cycle(1);
      repeat (5) cycle();
      chk("n1_tick", 32'(tick), 32'd1);
      chk("n1_clk", 32'(clock_out), 32'd1);

      // N=6 with enable held low mid-period for 7 cycles.
      load_cycle(6);
      run_to_count(5);
      run_to_count(3);
      enable = 1'b0;
      repeat (7) cycle();
      chk("frozen_count", 32'(count_out), 32'd3);
      enable = 1'b1;
      repeat (10) cycle();

      // Reset mid-period with N=9 pending.
      run_to_count(2);
      load_cycle(9);
      pulse_reset();
      chk("rst_pending", 32'(load_pending), 32'd0);
      chk("rst_count", 32'(count_out), 32'd0);
      repeat (9) cycle();

`ifdef PHASE_RESYNC_EN
      run_to_count(2);
      resync = 1'b1;
      cycle();
      resync = 1'b0;
      chk("resync_count", 32'(count_out), 32'd3);
      chk("resync_tick", 32'(tick), 32'd1);
      repeat (6) cycle();
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         enable   = ($urandom_range(9) != 0);
         div_load = ($urandom_range(24) == 0);
         case ($urandom_range(5))
            0: div_value = '0;
            1: div_value = W'(1);
            2: div_value = W'(2);
            3: div_value = W'(3);
            default: div_value = W'($urandom_range(40, 1));
         endcase
`ifdef PHASE_RESYNC_EN
         resync = ($urandom_range(39) == 0);
`endif
         if ($urandom_range(399) == 0) begin
            div_load = 1'b0;
            pulse_reset();
         end else begin
            cycle();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
